// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the Hi/Lo multiply/divide sequencer.
package muldiv_pkg;

    localparam int unsigned DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_WB
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_if.sv
// Pipeline-side bundle for the Hi/Lo multiply/divide sequencer.
// Optional: MULDIV_CANCEL_EN adds the cancel request.
interface muldiv_hilo_ctrl_if #(
    parameter int unsigned WIDTH = muldiv_pkg::DEF_WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mf_req;
`ifdef MULDIV_CANCEL_EN
    logic             cancel;
`endif
    logic             busy;
    logic             stall;
    logic             hilo_write;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             div_by_zero;

    modport master (
        output start, op, a, b, mf_req,
`ifdef MULDIV_CANCEL_EN
        output cancel,
`endif
        input  busy, stall, hilo_write, hi_out, lo_out, div_by_zero
    );

    modport slave (
        input  start, op, a, b, mf_req,
`ifdef MULDIV_CANCEL_EN
        input  cancel,
`endif
        output busy, stall, hilo_write, hi_out, lo_out, div_by_zero
    );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier or restoring divider.
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_out
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        sum    = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, opnd & {WIDTH{acc_in[0]}}};
        rem_sh = acc_in[2*WIDTH-1:WIDTH-1];
        fits   = rem_sh >= {1'b0, opnd};
        // Exact whenever fits is set, since the difference is then below the divisor.
        diff   = rem_sh[WIDTH-1:0] - opnd;
        if (!is_div) begin
            acc_out = {sum, acc_in[WIDTH-1:1]};
        end else if (fits) begin
            acc_out = {diff, acc_in[WIDTH-2:0], 1'b1};
        end else begin
            acc_out = {rem_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer producing Hi/Lo write data.
// Optional: MULDIV_CANCEL_EN squashes an operation in CALC or FIX.
module muldiv_hilo_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input logic               clk,
    input logic               rst_n,
    muldiv_hilo_ctrl_if.slave bus
);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic               a_neg_q, a_neg_d;
    logic               b_neg_q, b_neg_d;
    logic               dbz_pend_q, dbz_pend_d;
    logic               busy_q, busy_d;
    logic               hilo_write_q, hilo_write_d;
    logic [WIDTH-1:0]   hi_out_q, hi_out_d;
    logic [WIDTH-1:0]   lo_out_q, lo_out_d;
    logic               div_by_zero_q, div_by_zero_d;

    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] fix_res;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               calc_div, start_div;

    assign calc_div = op_is_div(op_q);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (calc_div),
        .acc_in  (acc_q),
        .opnd    (opnd_q),
        .acc_out (step_acc)
    );

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        opnd_d        = opnd_q;
        a_raw_d       = a_raw_q;
        a_neg_d       = a_neg_q;
        b_neg_d       = b_neg_q;
        dbz_pend_d    = dbz_pend_q;
        busy_d        = busy_q;
        hilo_write_d  = 1'b0;
        hi_out_d      = hi_out_q;
        lo_out_d      = lo_out_q;
        div_by_zero_d = div_by_zero_q;

        start_div = op_is_div(op_e'(bus.op));
        a_mag     = (op_is_signed(op_e'(bus.op)) && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag     = (op_is_signed(op_e'(bus.op)) && bus.b[WIDTH-1]) ? -bus.b : bus.b;

        // Sign correction; a_neg/b_neg are only ever set for signed ops.
        if (dbz_pend_q) begin
            fix_res = {a_raw_q, {WIDTH{1'b1}}};
        end else if (calc_div) begin
            fix_res[WIDTH-1:0]       = (a_neg_q ^ b_neg_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            fix_res[2*WIDTH-1:WIDTH] = a_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
            fix_res = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d          = op_e'(bus.op);
                    a_raw_d       = bus.a;
                    a_neg_d       = op_is_signed(op_e'(bus.op)) && bus.a[WIDTH-1];
                    b_neg_d       = op_is_signed(op_e'(bus.op)) && bus.b[WIDTH-1];
                    opnd_d        = start_div ? b_mag : a_mag;
                    acc_d         = {{WIDTH{1'b0}}, (start_div ? a_mag : b_mag)};
                    dbz_pend_d    = start_div && (bus.b == '0);
                    cnt_d         = '0;
                    div_by_zero_d = 1'b0;
                    busy_d        = 1'b1;
                    state_d       = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    div_by_zero_d = dbz_pend_q;
                    state_d       = S_FIX;
                end
            end
            S_FIX: begin
                hi_out_d     = fix_res[2*WIDTH-1:WIDTH];
                lo_out_d     = fix_res[WIDTH-1:0];
                hilo_write_d = 1'b1;
                state_d      = S_WB;
            end
            S_WB: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef MULDIV_CANCEL_EN
        if (bus.cancel && (state_q == S_CALC || state_q == S_FIX)) begin
            state_d       = S_IDLE;
            busy_d        = 1'b0;
            hilo_write_d  = 1'b0;
            hi_out_d      = hi_out_q;
            lo_out_d      = lo_out_q;
            div_by_zero_d = div_by_zero_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            op_q          <= OP_MULT;
            cnt_q         <= '0;
            acc_q         <= '0;
            opnd_q        <= '0;
            a_raw_q       <= '0;
            a_neg_q       <= 1'b0;
            b_neg_q       <= 1'b0;
            dbz_pend_q    <= 1'b0;
            busy_q        <= 1'b0;
            hilo_write_q  <= 1'b0;
            hi_out_q      <= '0;
            lo_out_q      <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            opnd_q        <= opnd_d;
            a_raw_q       <= a_raw_d;
            a_neg_q       <= a_neg_d;
            b_neg_q       <= b_neg_d;
            dbz_pend_q    <= dbz_pend_d;
            busy_q        <= busy_d;
            hilo_write_q  <= hilo_write_d;
            hi_out_q      <= hi_out_d;
            lo_out_q      <= lo_out_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.stall       = busy_q & bus.mf_req;
    assign bus.hilo_write  = hilo_write_q;
    assign bus.hi_out      = hi_out_q;
    assign bus.lo_out      = lo_out_q;
    assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Scoreboard bench for muldiv_hilo_ctrl; exercises cancel when MULDIV_CANCEL_EN is defined.
module tb_muldiv_hilo_ctrl;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_exp = 0;
    int   n_writes = 0;

    muldiv_hilo_ctrl_if #(.WIDTH(W)) bus ();

    muldiv_hilo_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    // Monitor: every write strobe is matched against the oldest queued result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.hilo_write === 1'b1) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got hi=0x%0h lo=0x%0h, want no write",
                             bus.hi_out, bus.lo_out);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_hi", bus.hi_out, e.hi);
                    check("wb_lo", bus.lo_out, e.lo);
                    check("wb_dbz", bus.div_by_zero, e.dbz);
                end
            end
        end
    end

    task automatic launch(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = o; bus.a = av; bus.b = bv;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic expect_wb(input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed);
        exp_t e;
        e.hi = eh; e.lo = el; e.dbz = ed;
        exp_q.push_back(e);
        n_exp++;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed,
                          input string tag);
        int busy_bad = 0;
        int wcnt = 0;
        int wcyc = 0;
        expect_wb(eh, el, ed);
        launch(o, av, bv);
        for (int k = 1; k <= W + 4; k++) begin
            @(negedge clk);
            if (k == 1) check({tag, "_dbz_clr"}, bus.div_by_zero, 0);
            if (bus.busy !== (k <= W + 2)) busy_bad++;
            if (bus.hilo_write === 1'b1) begin wcnt++; wcyc = k; end
            @(posedge clk); #1;
        end
        check({tag, "_busy_window"}, busy_bad, 0);
        check({tag, "_write_count"}, wcnt, 1);
        check({tag, "_write_cycle"}, wcyc, W + 2);
        check({tag, "_hold_hi"}, bus.hi_out, eh);
        check({tag, "_hold_lo"}, bus.lo_out, el);
        check({tag, "_dbz_hold"}, bus.div_by_zero, ed);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wcnt;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0; bus.mf_req = 1'b1;
`ifdef MULDIV_CANCEL_EN
        bus.cancel = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_write", bus.hilo_write, 0);
        check("rst_hi", bus.hi_out, 0);
        check("rst_lo", bus.lo_out, 0);
        check("rst_dbz", bus.div_by_zero, 0);
        check("rst_stall", bus.stall, 0);
        bus.mf_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_neg");
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, "mult_minsq");
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0, "mult_m1sq");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg_a");
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, "div_neg_b");
        run_op(2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3, 1'b0, "div_neg_ab");
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "divu");
        run_op(2'b11, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 1'b1, "divu_zero");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, "div_ovf");
        run_op(2'b10, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, "div_zero_s");
        run_op(2'b11, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, "divu_exact");

        // mf_req during CALC with a second start held through WB.
        expect_wb(32'd0, 32'd42, 1'b0);
        launch(2'b01, 32'd6, 32'd7);
        wcnt = 0;
        for (int k = 1; k <= 37; k++) begin
            if (k == 10) begin
                bus.mf_req = 1'b1; bus.start = 1'b1;
                bus.op = 2'b11; bus.a = 32'd50; bus.b = 32'd5;
            end
            if (k == 35) bus.start = 1'b0;
            if (k == 36) bus.mf_req = 1'b0;
            @(negedge clk);
            if (bus.hilo_write === 1'b1) wcnt++;
            if (k == 9)  check("stall_before_req", bus.stall, 0);
            if (k == 10) check("stall_asserted", bus.stall, 1);
            if (k == 34) check("stall_in_wb", bus.stall, 1);
            if (k == 35) check("stall_released", bus.stall, 0);
            if (k == 37) check("second_start_ignored", bus.busy, 0);
            @(posedge clk); #1;
        end
        check("stall_write_count", wcnt, 1);
        check("stall_hold_lo", bus.lo_out, 42);

`ifdef MULDIV_CANCEL_EN
        launch(2'b01, 32'h0001_0000, 32'h0001_0000);
        wcnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 20) bus.cancel = 1'b1;
            if (k == 21) bus.cancel = 1'b0;
            @(negedge clk);
            if (bus.hilo_write === 1'b1) wcnt++;
            if (k == 20) check("cancel_busy_before", bus.busy, 1);
            if (k == 22) check("cancel_busy_dropped", bus.busy, 0);
            @(posedge clk); #1;
        end
        check("cancel_no_write", wcnt, 0);
        check("cancel_keep_hi", bus.hi_out, 0);
        check("cancel_keep_lo", bus.lo_out, 42);
`endif

        // Asynchronous reset part-way through a MULT.
        launch(2'b00, 32'd5, 32'd5);
        wcnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 15) begin
                rst_n = 1'b0;
                #1;
                check("midrst_busy", bus.busy, 0);
                check("midrst_hi", bus.hi_out, 0);
                check("midrst_lo", bus.lo_out, 0);
                check("midrst_write", bus.hilo_write, 0);
            end
            if (k == 17) rst_n = 1'b1;
            @(negedge clk);
            if (bus.hilo_write === 1'b1) wcnt++;
            @(posedge clk); #1;
        end
        check("midrst_no_write", wcnt, 0);
        check("midrst_idle", bus.busy, 0);

        run_op(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, "after_rst");

        repeat (3) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("total_writes", n_writes, n_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
